// File: rtl/control_filtro_mac_pkg.sv
// -----------------------------------------------------------------------------
// control_filtro_mac_pkg
// Shared definitions for the FIR MAC sequencer:
//   - estado_t       : sequencer state encoding (IDLE / MAC / SAT)
//   - *_DEF          : default sample / coefficient widths and fraction bits
//   - SAT_MAX/SAT_MIN: output clamp limits for the default sample width
//   - sat_max_f/sat_min_f : clamp limits for any signed width
// -----------------------------------------------------------------------------
package control_filtro_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_SAT  = 2'd2
  } estado_t;

  localparam int DATA_W_DEF    = 12;
  localparam int COEF_W_DEF    = 16;
  localparam int COEF_FRAC_DEF = 15;

  function automatic longint sat_max_f(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_min_f(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

  localparam longint SAT_MAX = sat_max_f(DATA_W_DEF);
  localparam longint SAT_MIN = sat_min_f(DATA_W_DEF);

endpackage

// File: rtl/control_filtro_mac_sat_redondeo.sv
// -----------------------------------------------------------------------------
// sat_redondeo
// Combinational output stage of the FIR: rounds the accumulator half-up,
// drops the coefficient fraction bits with an arithmetic shift and clamps the
// result to the signed DATA_W range.
// Ports:
//   acc_i   in  ACC_W   signed accumulator value
//   dato_o  out DATA_W  signed rounded and saturated sample
// -----------------------------------------------------------------------------
module sat_redondeo
  import control_filtro_mac_pkg::*;
#(
  parameter int ACC_W     = DATA_W_DEF + COEF_W_DEF + 5,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int COEF_FRAC = COEF_FRAC_DEF
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] dato_o
);

  // One guard bit so that adding the half-LSB can never wrap.
  localparam int SUM_W = ACC_W + 1;

  localparam logic signed [SUM_W-1:0] HALF    = SUM_W'(longint'(1) << (COEF_FRAC - 1));
  localparam logic signed [SUM_W-1:0] LIM_MAX = SUM_W'(sat_max_f(DATA_W));
  localparam logic signed [SUM_W-1:0] LIM_MIN = SUM_W'(sat_min_f(DATA_W));

  logic signed [SUM_W-1:0] suma;
  logic signed [SUM_W-1:0] desplazado;

  assign suma       = SUM_W'(acc_i) + HALF;
  assign desplazado = suma >>> COEF_FRAC;

  always_comb begin
    dato_o = desplazado[DATA_W-1:0];
    if (desplazado > LIM_MAX) begin
      dato_o = LIM_MAX[DATA_W-1:0];
    end else if (desplazado < LIM_MIN) begin
      dato_o = LIM_MIN[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/control_filtro_mac.sv
// -----------------------------------------------------------------------------
// control_filtro_mac
// Sequencer for a time-shared FIR filter. On every sample tick it shifts the
// new sample into the delay line, walks the coefficient ROM one tap per cycle
// through a single signed MAC, then rounds/saturates and strobes the result.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for Enable; coef_addr parked at 0
//   MAC   | one tap per cycle, acc += x[k]*coef_data, k = 0..N_TAPS-1
//   SAT   | round/clamp (or bypass x[0]) into muestra_out, strobe valid
//
// Ports:
//   CLK           in   system clock
//   Reset         in   synchronous active-high reset
//   Enable        in   1-cycle sample tick
//   muestra_in    in   DATA_W signed input sample (valid with Enable)
//   bypass        in   1: output the captured sample instead of the filter
//   coef_addr     out  coefficient ROM address (registered tap index)
//   coef_data     in   COEF_W signed coefficient, async ROM read of coef_addr
//   muestra_out   out  DATA_W signed output sample, held between updates
//   salida_valida out  1-cycle strobe when muestra_out updates
//   ocupado       out  high while in MAC or SAT
//   overrun       out  sticky: a tick arrived while the sequencer was busy
// -----------------------------------------------------------------------------
module control_filtro_mac
  import control_filtro_mac_pkg::*;
#(
  parameter int N_TAPS    = 5,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int COEF_W    = COEF_W_DEF,
  parameter int COEF_FRAC = COEF_FRAC_DEF,
  parameter int ACC_W     = DATA_W + COEF_W + 5
) (
  input  logic                        CLK,
  input  logic                        Reset,
  input  logic                        Enable,
  input  logic signed [DATA_W-1:0]    muestra_in,
  input  logic                        bypass,
  output logic [$clog2(N_TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]    coef_data,
  output logic signed [DATA_W-1:0]    muestra_out,
  output logic                        salida_valida,
  output logic                        ocupado,
  output logic                        overrun
);

  localparam int AW   = $clog2(N_TAPS);
  localparam int PR_W = DATA_W + COEF_W;
  localparam logic [AW-1:0] K_LAST = AW'(N_TAPS - 1);

  estado_t estado_q, estado_d;
  logic [AW-1:0] k_q, k_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [DATA_W-1:0] x_q [N_TAPS];
  logic signed [DATA_W-1:0] x_d [N_TAPS];
  logic signed [DATA_W-1:0] muestra_out_q, muestra_out_d;
  logic valida_q, valida_d;
  logic overrun_q, overrun_d;

  logic signed [PR_W-1:0]   producto;
  logic signed [DATA_W-1:0] sat_out;

  // Full-precision signed product; both operands are signed so the multiply
  // is done at PR_W bits with proper sign extension.
  assign producto = x_q[k_q] * coef_data;

  sat_redondeo #(
    .ACC_W     (ACC_W),
    .DATA_W    (DATA_W),
    .COEF_FRAC (COEF_FRAC)
  ) u_sat (
    .acc_i  (acc_q),
    .dato_o (sat_out)
  );

  always_comb begin
    estado_d      = estado_q;
    k_d           = k_q;
    acc_d         = acc_q;
    x_d           = x_q;
    muestra_out_d = muestra_out_q;
    valida_d      = 1'b0;
    overrun_d     = overrun_q;

    unique case (estado_q)
      ST_IDLE: begin
        if (Enable) begin
          x_d[0] = muestra_in;
          for (int i = 1; i < N_TAPS; i++) begin
            x_d[i] = x_q[i-1];
          end
          acc_d    = '0;
          k_d      = '0;
          estado_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + ACC_W'(producto);
        if (k_q == K_LAST) begin
          k_d      = '0;
          estado_d = ST_SAT;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      ST_SAT: begin
        muestra_out_d = bypass ? x_q[0] : sat_out;
        valida_d      = 1'b1;
        estado_d      = ST_IDLE;
      end
      default: begin
        estado_d = ST_IDLE;
        k_d      = '0;
      end
    endcase

    // A tick while busy (including the SAT->IDLE cycle) is dropped and flagged.
    if (Enable && (estado_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      estado_q      <= ST_IDLE;
      k_q           <= '0;
      acc_q         <= '0;
      muestra_out_q <= '0;
      valida_q      <= 1'b0;
      overrun_q     <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        x_q[i] <= '0;
      end
    end else begin
      estado_q      <= estado_d;
      k_q           <= k_d;
      acc_q         <= acc_d;
      muestra_out_q <= muestra_out_d;
      valida_q      <= valida_d;
      overrun_q     <= overrun_d;
      x_q           <= x_d;
    end
  end

  assign coef_addr     = k_q;
  assign muestra_out   = muestra_out_q;
  assign salida_valida = valida_q;
  assign ocupado       = (estado_q != ST_IDLE);
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_control_filtro_mac.sv
module tb_control_filtro_mac;

  logic              CLK = 1'b0;
  logic              Reset;
  logic              Enable;
  logic signed [11:0] muestra_in;
  logic              bypass;
  logic [2:0]        coef_addr;
  logic signed [15:0] coef_data;
  logic signed [11:0] muestra_out;
  logic              salida_valida;
  logic              ocupado;
  logic              overrun;

  logic              rom_sat;

  localparam logic signed [15:0] ROM_A [0:4] = '{16'sh2000, 16'sh4000, 16'sh6000, 16'sh4000, 16'sh2000};

  always #5 CLK = ~CLK;

  always_comb begin
    coef_data = 16'sh0000;
    if (rom_sat) coef_data = 16'sh7FFF;
    else if (coef_addr < 3'd5) coef_data = ROM_A[coef_addr];
  end

  control_filtro_mac dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .Enable        (Enable),
    .muestra_in    (muestra_in),
    .bypass        (bypass),
    .coef_addr     (coef_addr),
    .coef_data     (coef_data),
    .muestra_out   (muestra_out),
    .salida_valida (salida_valida),
    .ocupado       (ocupado),
    .overrun       (overrun)
  );

  typedef struct {
    logic rom_sat;
    int   muestra;
    int   esperado;
  } vec_t;

  vec_t tabla [16];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulso_reset();
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
  endtask

  // Pulses Enable for one cycle, then counts edges after e0 until the strobe.
  task automatic muestra(input int s, input logic byp, output int salida, output int lat);
    Enable     = 1'b1;
    muestra_in = 12'(s);
    bypass     = byp;
    @(posedge CLK); #1;
    Enable = 1'b0;
    lat = 0;
    while (!salida_valida && lat < 50) begin
      @(posedge CLK); #1;
      lat++;
    end
    salida = int'(muestra_out);
    bypass = 1'b0;
  endtask

  task automatic run_tabla(input int first, input int last, input int gap);
    int out, lat;
    for (int i = first; i <= last; i++) begin
      rom_sat = tabla[i].rom_sat;
      muestra(tabla[i].muestra, 1'b0, out, lat);
      chk($sformatf("tabla[%0d].salida", i), out, tabla[i].esperado);
      chk($sformatf("tabla[%0d].latencia", i), lat, 6);
      repeat (gap) @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    int out, lat, strobes;

    tabla[0]  = '{1'b0, 1000, 250};
    tabla[1]  = '{1'b0, 0, 500};
    tabla[2]  = '{1'b0, 0, 750};
    tabla[3]  = '{1'b0, 0, 500};
    tabla[4]  = '{1'b0, 0, 250};
    tabla[5]  = '{1'b0, 0, 0};
    tabla[6]  = '{1'b1, 2047, 2047};
    tabla[7]  = '{1'b1, 2047, 2047};
    tabla[8]  = '{1'b1, 2047, 2047};
    tabla[9]  = '{1'b1, 2047, 2047};
    tabla[10] = '{1'b1, 2047, 2047};
    tabla[11] = '{1'b1, -2048, 2047};
    tabla[12] = '{1'b1, -2048, 2045};
    tabla[13] = '{1'b1, -2048, -2048};
    tabla[14] = '{1'b1, -2048, -2048};
    tabla[15] = '{1'b1, -2048, -2048};

    Reset = 1'b1; Enable = 1'b0; muestra_in = '0; bypass = 1'b0; rom_sat = 1'b0;

    // Reset held two cycles
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_muestra_out", int'(muestra_out), 0);
    chk("rst_valida", int'(salida_valida), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_coef_addr", int'(coef_addr), 0);
    Reset = 1'b0;
    @(posedge CLK); #1;

    // Impulse response with ticks ~1135 cycles apart
    run_tabla(0, 5, 1128);

    // Cycle-accurate timing of one sequence
    Enable = 1'b1; muestra_in = 12'sd1000;
    @(posedge CLK); #1;
    Enable = 1'b0;
    chk("t_addr_e0", int'(coef_addr), 0);
    chk("t_ocup_e0", int'(ocupado), 1);
    for (int j = 1; j <= 4; j++) begin
      @(posedge CLK); #1;
      chk($sformatf("t_addr_e%0d", j), int'(coef_addr), j);
      chk($sformatf("t_ocup_e%0d", j), int'(ocupado), 1);
      chk($sformatf("t_valida_e%0d", j), int'(salida_valida), 0);
    end
    @(posedge CLK); #1;
    chk("t_ocup_e5", int'(ocupado), 1);
    chk("t_valida_e5", int'(salida_valida), 0);
    @(posedge CLK); #1;
    chk("t_valida_e6", int'(salida_valida), 1);
    chk("t_ocup_e6", int'(ocupado), 0);
    chk("t_addr_e6", int'(coef_addr), 0);
    chk("t_salida_e6", int'(muestra_out), 250);
    @(posedge CLK); #1;
    chk("t_valida_e7", int'(salida_valida), 0);
    chk("t_hold_e7", int'(muestra_out), 250);

    // Overrun: second tick 3 cycles after the first is dropped
    pulso_reset();
    chk("ovr_tras_reset", int'(overrun), 0);
    Enable = 1'b1; muestra_in = 12'sd1000;
    @(posedge CLK); #1;
    Enable = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    Enable = 1'b1; muestra_in = 12'sd500;
    @(posedge CLK); #1;
    Enable = 1'b0;
    chk("ovr_set", int'(overrun), 1);
    lat = 3;
    while (!salida_valida && lat < 50) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk("ovr_latencia", lat, 6);
    chk("ovr_salida", int'(muestra_out), 250);
    repeat (5) @(posedge CLK);
    #1;
    chk("ovr_sticky", int'(overrun), 1);
    muestra(0, 1'b0, out, lat);
    chk("ovr_x0_no_500", out, 500);
    chk("ovr_sticky2", int'(overrun), 1);

    // Reset at e3 of a sequence: no strobe, state cleared
    Enable = 1'b1; muestra_in = 12'sd1000;
    @(posedge CLK); #1;
    Enable = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    chk("rmac_ocupado", int'(ocupado), 0);
    chk("rmac_overrun", int'(overrun), 0);
    chk("rmac_addr", int'(coef_addr), 0);
    chk("rmac_salida", int'(muestra_out), 0);
    strobes = 0;
    for (int j = 0; j < 10; j++) begin
      @(posedge CLK); #1;
      if (salida_valida) strobes++;
    end
    chk("rmac_sin_strobe", strobes, 0);

    run_tabla(0, 5, 20);

    // Bypass: filter would give -2, bypass must give the raw sample
    muestra(-7, 1'b1, out, lat);
    chk("byp_salida", out, -7);
    chk("byp_latencia", lat, 6);
    repeat (3) @(posedge CLK);
    #1;

    // Saturation with an all-0x7FFF ROM
    pulso_reset();
    run_tabla(6, 15, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_filtro_mac.md
Name: control_filtro_mac

Overview:
- Sequencer for the FIR filter datapath. It time-shares one signed multiplier-accumulator across all taps.
- On each sample tick (the 1-cycle Enable pulse from the frequency divider), it:
  - captures the input sample into the delay line;
  - walks the coefficient ROM address by address, accumulating one tap per cycle;
  - rounds and saturates the result, then presents it to the output stage with a valid strobe.

Parameters:
N_TAPS, 5, number of filter taps (2..32)
DATA_W, 12, sample width, signed two's complement
COEF_W, 16, coefficient width, signed Q1.15
COEF_FRAC, 15, fractional bits in coefficients (right-shift amount)
ACC_W, DATA_W+COEF_W+5, accumulator width, signed

Ports:
CLK  in  1  system clock
Reset  in  1  synchronous, active-high reset
Enable  in  1  sample tick, 1-cycle pulse from frequency divider
muestra_in  in  DATA_W  signed input sample, valid when Enable=1
bypass  in  1  1: output = captured sample (filter disabled), same latency
coef_addr  out  clog2(N_TAPS)  coefficient ROM address
coef_data  in  COEF_W  signed coefficient; combinational (asynchronous) ROM read of coef_addr
muestra_out  out  DATA_W  signed filtered sample, held between updates
salida_valida  out  1  1-cycle strobe when muestra_out updates
ocupado  out  1  1 while in MAC or SAT
overrun  out  1  sticky: Enable arrived while not IDLE

Behaviour:
- Reset values (applied at the clock edge when Reset=1):
  - muestra_out=0, salida_valida=0, ocupado=0, overrun=0, coef_addr=0;
  - delay line x[0..N_TAPS-1]=0, accumulator=0, k=0, state=IDLE.
- Reset overrides all other activity, including reset mid-MAC: the partial result is discarded and no strobe is produced.
- FSM states: IDLE, MAC, SAT.
- IDLE, edge e0 with Enable=1:
  - shift x[i]<=x[i-1] for i>0, and x[0]<=muestra_in;
  - acc<=0, k<=0, go to MAC.
  - With Enable=0: stay in IDLE.
- MAC:
  - coef_addr = k, registered, and valid for the whole cycle.
  - At each edge: acc <= acc + x[k]*coef_data, with a full-precision signed product of DATA_W+COEF_W bits, sign-extended to ACC_W; k<=k+1.
  - After the edge where k=N_TAPS-1: go to SAT.
  - MAC lasts exactly N_TAPS cycles (edges e1..eN).
- SAT, edge e(N+1):
  - r = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC, i.e. round half up with an arithmetic shift.
  - Clamp r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - muestra_out<=clamped r, or x[0] when bypass=1 (bypass is sampled in SAT).
  - salida_valida<=1 for exactly one cycle; go to IDLE.
- Latency: salida_valida is high in the cycle following edge e(N_TAPS+1).
  - For N_TAPS=5: edge e6, i.e. 6 edges after the edge that sampled Enable.
- ocupado=1 exactly while state is MAC or SAT.
- Overrun:
  - Enable=1 sampled in MAC or SAT sets overrun<=1, which stays set until Reset.
  - The sample is dropped: the delay line and the sequence in progress are unaffected.
  - Enable in the same cycle as the SAT-to-IDLE transition also counts as overrun.
- Wrap-around: k never exceeds N_TAPS-1; coef_addr returns to 0 in IDLE.
- Accumulator overflow is impossible for |coef|<1 and N_TAPS<=32, given the ACC_W sizing.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE/MAC/SAT);
  - DATA_W/COEF_W/COEF_FRAC defaults;
  - saturation limit constants SAT_MAX/SAT_MIN.
- One sub-module, sat_redondeo (combinational): ACC_W input, rounding + shift + clamp, DATA_W output.
- FSM, counter, delay line and MAC stay in the top module.

Test Plan (N_TAPS=5; bench ROM coefs = 0x2000, 0x4000, 0x6000, 0x4000, 0x2000):
- Reset held 2 cycles -> muestra_out=0, salida_valida=0, ocupado=0, overrun=0, coef_addr=0.
- Impulse: muestra_in=1000 on first Enable, 0 on the next 5 Enables (spaced 1135 cycles) -> muestra_out sequence 250, 500, 750, 500, 250, 0.
- Timing:
  - Enable sampled at edge e0 -> coef_addr=0,1,2,3,4 on cycles after e0..e4;
  - salida_valida high only in the cycle after e6;
  - ocupado high from after e0 through before e6.
- Saturation (ROM all 0x7FFF):
  - constant 2047 for 5 Enables -> muestra_out=2047;
  - constant -2048 -> muestra_out=-2048.
- Overrun: second Enable 3 cycles after the first (muestra_in=500) -> overrun=1 and stays 1; the next output equals the single-sample result (1000->250); x[0] is not 500.
- Reset mid-MAC (at edge e3) + bypass:
  - reset -> no strobe; the next impulse reproduces the impulse sequence from a zero state;
  - bypass=1 with muestra_in=-7 -> muestra_out=-7 after the same 6-edge latency.
